ball_motion: RTL and testbench
==============================

# ball_motion

Per-frame ball physics for the labyrinth game; sits directly upstream of the VGA subsystem and drives its `ball_loc_X`, `ball_loc_Y` and `gameover` inputs. Once per video frame it integrates latched accelerometer tilt into a saturating velocity and moves the ball. Before committing a move it probes the world map for walls, then checks whether the ball centre sits on a goal cell. It runs on the 25 MHz pixel clock, so `vert_sync` arrives in-domain.

## Interface
- `SCREEN_W`, 640, visible width in pixels
- `SCREEN_H`, 480, visible height in pixels
- `ICON_SIZE`, 16, ball icon edge length in pixels (power of two, ≥4)
- `VEL_MAX`, 7, velocity magnitude limit in pixels/frame (1..15)
- `START_X`, 16, reset X position (icon top-left)
- `START_Y`, 16, reset Y position (icon top-left)
- `ACK_TIMEOUT`, 15, map-probe wait limit in cycles

Ports:
- `sys_clk`  in  1  25 MHz pixel clock
- `sys_rst`  in  1  reset, synchronous, active-high
- `vert_sync`  in  1  active-low vertical sync from the display timing generator
- `accel_x`  in  8  signed X tilt sample
- `accel_y`  in  8  signed Y tilt sample
- `accel_valid`  in  1  one-cycle strobe; qualifies `accel_x` and `accel_y`
- `map_req`  out  1  map probe request
- `map_addr_x`  out  10  probe pixel column
- `map_addr_y`  out  10  probe pixel row
- `map_ack`  in  1  probe response valid
- `map_cell`  in  2  probe cell type: 00 floor, 01 wall, 10 goal, 11 treated as wall
- `ball_loc_X`  out  10  icon top-left column
- `ball_loc_Y`  out  10  icon top-left row
- `gameover`  out  1  sticky: goal reached

## Operation
- **Accelerometer latch:** any `accel_valid` strobe loads the holding registers `ax`, `ay`, regardless of FSM state. Both hold 0 after reset.
- **Frame start:** a falling edge of `vert_sync`, detected with one register stage. A frame start is acted on only in IDLE; if it arrives in any other state it is dropped.
- **FSM states:** IDLE → VEL → PROBE_X → PROBE_Y → GOAL → COMMIT → IDLE. While `gameover`=1 the FSM stays in IDLE.
- **VEL:**
  - `vx += ax>>>4`, `vy += ay>>>4` (arithmetic shift).
  - Velocities are signed 5-bit registers, saturated to ±`VEL_MAX`.
- **PROBE_X:**
  - Candidate `cx = x + vx`, computed at 11-bit signed width.
  - Clamp `cx` to [0, `SCREEN_W-ICON_SIZE`]. If clamping occurs, `vx` is set to 0.
  - If the clamped `cx` ≠ `x`, probe the leading edge: column `cx+ICON_SIZE-1` when `vx`>0, or `cx` when `vx`<0; row `y+ICON_SIZE/2`.
  - Result wall: `vx`←0 and the working x stays unchanged. Result floor or goal: working x←`cx`.
  - If the clamped `cx` equals `x`, no request is issued.
- **PROBE_Y:** same as PROBE_X with the axes swapped, using the updated working x. Leading-edge column is `x+ICON_SIZE/2`.
- **GOAL:** probe the ball centre (`x+ICON_SIZE/2`, `y+ICON_SIZE/2`). If `map_cell`=10, a set-flag is raised.
- **COMMIT:** loads `ball_loc_X`, `ball_loc_Y` from the working x/y, and sets `gameover` if the flag is raised.
- **Probe handshake:**
  - `map_req` rises with `map_addr_x`/`map_addr_y` valid. Address and request hold stable until `map_ack`.
  - `map_cell` is sampled in the cycle where `map_ack`=1. `map_req` drops on the next edge.
  - `map_ack` is ignored while `map_req`=0.
  - If `map_ack` does not arrive within `ACK_TIMEOUT` cycles, the probe result is taken as wall, and as not-goal in the GOAL state.

## Timing
- **Reset values:**
  - `ball_loc_X`=`START_X`, `ball_loc_Y`=`START_Y`.
  - `gameover`=0, `map_req`=0, `map_addr_x`=`map_addr_y`=0.
  - `vx`=`vy`=0, FSM in IDLE.
- **Reset mid-handshake:** `map_req` is 0 after the reset edge and the pending probe is abandoned.
- **Earliest acknowledge:** `map_ack` may assert at the earliest one cycle after `map_req` rises. A same-cycle acknowledge is not used.
- **Minimum latency:** with both axes moving and one-cycle acks, frame-start edge detected at cycle 0:
  - VEL at cycle 1.
  - Probe requests at cycles 2, 4, 6; acks at cycles 3, 5, 7.
  - Outputs valid after the COMMIT edge at cycle 8.
- **Output stability:** the outputs change only on the COMMIT edge. They are stable across the entire active video period.

## Configuration
- **`BALL_FRICTION_EN` defined:** in VEL, an axis whose `a>>>4` equals 0 has its velocity moved one step toward 0 (never past 0).
- **`BALL_FRICTION_EN` undefined:** velocity is retained when there is no tilt.

## Test plan
- **Reset:** reset, then one frame with `ax`=`ay`=0 and all probes floor → `ball_loc` stays (16,16), `gameover`=0, no `map_req` issued.
- **Saturation:** `accel_x`=+127 held for 3 frames on an all-floor map → `vx` becomes 7 then saturates; `ball_loc_X` goes 16→23→30→37.
- **Wall hit:** `vx`=+4 and the probe at column 35, row 24 returns 01 → `ball_loc_X` unchanged and `vx`=0 for the next frame.
- **Screen-edge clamp:** ball at X=622 with `vx`=+5 → `ball_loc_X`=624, `vx` zeroed; the probe occurs at column 639.
- **Ack timeout:** `map_ack` withheld → `map_req` drops after 15 cycles and the move is blocked. A further frame start arriving while busy is ignored.
- **Goal:** the centre probe returns 10 → `gameover`=1 after COMMIT; later frames issue no requests and the position stays frozen until `sys_rst`.

Source files
------------

// File: rtl/ball_motion.sv
`timescale 1ns/1ps
// ball_motion: once per video frame, integrates latched tilt into velocity, moves the ball with
// wall probes against the map, and latches gameover on a goal cell. Optional macro: BALL_FRICTION_EN.
module ball_motion #(
    parameter int SCREEN_W    = 640,
    parameter int SCREEN_H    = 480,
    parameter int ICON_SIZE   = 16,
    parameter int VEL_MAX     = 7,
    parameter int START_X     = 16,
    parameter int START_Y     = 16,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       vert_sync,
    input  logic [7:0] accel_x,
    input  logic [7:0] accel_y,
    input  logic       accel_valid,
    output logic       map_req,
    output logic [9:0] map_addr_x,
    output logic [9:0] map_addr_y,
    input  logic       map_ack,
    input  logic [1:0] map_cell,
    output logic [9:0] ball_loc_X,
    output logic [9:0] ball_loc_Y,
    output logic       gameover
);
    localparam logic [9:0]        X_LIM   = 10'(SCREEN_W - ICON_SIZE);
    localparam logic [9:0]        Y_LIM   = 10'(SCREEN_H - ICON_SIZE);
    localparam logic [9:0]        HALF    = 10'(ICON_SIZE / 2);
    localparam logic [9:0]        EDGE    = 10'(ICON_SIZE - 1);
    localparam int                TW      = $clog2(ACK_TIMEOUT + 1);
    localparam logic [TW-1:0]     TO_LAST = TW'(ACK_TIMEOUT - 1);
    localparam logic signed [6:0] VPOS    = 7'(VEL_MAX);
    localparam logic signed [6:0] VNEG    = -VPOS;

    typedef enum logic [2:0] {IDLE, VEL, PROBE_X, PROBE_Y, GOAL, COMMIT} state_t;

    function automatic logic signed [4:0] sat_vel(input logic signed [6:0] s);
        if (s > VPOS) return VPOS[4:0];
        if (s < VNEG) return VNEG[4:0];
        return s[4:0];
    endfunction

    function automatic logic signed [4:0] vel_next(input logic signed [4:0] v,
                                                   input logic signed [7:0] a);
        logic signed [6:0] step;
        logic signed [6:0] sum;
        step = 7'(a >>> 4);
`ifdef BALL_FRICTION_EN
        if (step == 7'sd0) begin
            if (v > 5'sd0) return v - 5'sd1;
            if (v < 5'sd0) return v + 5'sd1;
            return v;
        end
`endif
        sum = $signed({{2{v[4]}}, v}) + step;
        return sat_vel(sum);
    endfunction

    function automatic logic [9:0] clamp_pos(input logic signed [10:0] c, input logic [9:0] hi);
        if (c < 11'sd0) return 10'd0;
        if (c > $signed({1'b0, hi})) return hi;
        return c[9:0];
    endfunction

    state_t            state_q;
    logic              vs_q;
    logic signed [7:0] ax_q, ay_q;
    logic signed [4:0] vx_q, vy_q;
    logic [9:0]        x_q, y_q, cand_q;
    logic [9:0]        loc_x_q, loc_y_q, addr_x_q, addr_y_q;
    logic              req_q, goal_q, over_q;
    logic [TW-1:0]     tmo_q;

    logic              frame_start;
    logic signed [4:0] axis_vel;
    logic [9:0]        axis_pos, axis_lim, cand_d, lead_d, addr_x_d, addr_y_d;
    logic signed [10:0] raw;
    logic              clamp_hit;

    assign frame_start = vs_q & ~vert_sync;

    // Shared candidate/clamp/leading-edge path for whichever axis is being probed.
    always_comb begin
        axis_pos  = (state_q == PROBE_Y) ? y_q : x_q;
        axis_vel  = (state_q == PROBE_Y) ? vy_q : vx_q;
        axis_lim  = (state_q == PROBE_Y) ? Y_LIM : X_LIM;
        raw       = $signed({1'b0, axis_pos}) + $signed({{6{axis_vel[4]}}, axis_vel});
        clamp_hit = (raw < 11'sd0) || (raw > $signed({1'b0, axis_lim}));
        cand_d    = clamp_pos(raw, axis_lim);
        lead_d    = (axis_vel > 5'sd0) ? cand_d + EDGE : cand_d;
        if (state_q == PROBE_Y) begin
            addr_x_d = x_q + HALF;
            addr_y_d = lead_d;
        end else begin
            addr_x_d = lead_d;
            addr_y_d = y_q + HALF;
        end
    end

    always_ff @(posedge sys_clk) begin
        vs_q <= vert_sync;
        if (sys_rst) begin
            state_q  <= IDLE;
            ax_q     <= '0;
            ay_q     <= '0;
            vx_q     <= '0;
            vy_q     <= '0;
            x_q      <= 10'(START_X);
            y_q      <= 10'(START_Y);
            loc_x_q  <= 10'(START_X);
            loc_y_q  <= 10'(START_Y);
            addr_x_q <= '0;
            addr_y_q <= '0;
            req_q    <= 1'b0;
            goal_q   <= 1'b0;
            over_q   <= 1'b0;
            tmo_q    <= '0;
        end else begin
            if (accel_valid) begin
                ax_q <= accel_x;
                ay_q <= accel_y;
            end
            case (state_q)
                IDLE: if (frame_start && !over_q) state_q <= VEL;
                VEL: begin
                    vx_q    <= vel_next(vx_q, ax_q);
                    vy_q    <= vel_next(vy_q, ay_q);
                    goal_q  <= 1'b0;
                    state_q <= PROBE_X;
                end
                PROBE_X, PROBE_Y: begin
                    if (!req_q) begin
                        if (clamp_hit) begin
                            if (state_q == PROBE_X) vx_q <= '0;
                            else vy_q <= '0;
                        end
                        if (cand_d != axis_pos) begin
                            req_q    <= 1'b1;
                            addr_x_q <= addr_x_d;
                            addr_y_q <= addr_y_d;
                            cand_q   <= cand_d;
                            tmo_q    <= '0;
                        end else begin
                            state_q <= (state_q == PROBE_X) ? PROBE_Y : GOAL;
                        end
                    end else if (map_ack || tmo_q == TO_LAST) begin
                        req_q   <= 1'b0;
                        state_q <= (state_q == PROBE_X) ? PROBE_Y : GOAL;
                        // Cells 00 and 10 are passable; 01, 11 and a timeout block the move.
                        if (map_ack && !map_cell[0]) begin
                            if (state_q == PROBE_X) x_q <= cand_q;
                            else y_q <= cand_q;
                        end else begin
                            if (state_q == PROBE_X) vx_q <= '0;
                            else vy_q <= '0;
                        end
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end
                GOAL: begin
                    if (!req_q) begin
                        // A ball that did not move this frame sits on the same, non-goal cell.
                        if (x_q != loc_x_q || y_q != loc_y_q) begin
                            req_q    <= 1'b1;
                            addr_x_q <= x_q + HALF;
                            addr_y_q <= y_q + HALF;
                            tmo_q    <= '0;
                        end else begin
                            state_q <= COMMIT;
                        end
                    end else if (map_ack || tmo_q == TO_LAST) begin
                        req_q   <= 1'b0;
                        goal_q  <= map_ack && (map_cell == 2'b10);
                        state_q <= COMMIT;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end
                COMMIT: begin
                    loc_x_q <= x_q;
                    loc_y_q <= y_q;
                    over_q  <= over_q | goal_q;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign map_req    = req_q;
    assign map_addr_x = addr_x_q;
    assign map_addr_y = addr_y_q;
    assign ball_loc_X = loc_x_q;
    assign ball_loc_Y = loc_y_q;
    assign gameover   = over_q;

endmodule

// File: tb/tb_ball_motion.sv
`timescale 1ns/1ps
// Directed bench for ball_motion: per-frame expectations go through a scoreboard queue and are
// compared once the frame has had time to commit; a map responder serves probe requests.
module tb_ball_motion;
    logic clk = 1'b0;
    always #20 clk = ~clk;

    logic       sys_rst, vert_sync, accel_valid, map_req, gameover;
    logic [7:0] accel_x, accel_y;
    logic       map_ack = 1'b0;
    logic [1:0] map_cell = 2'b00;
    logic [9:0] map_addr_x, map_addr_y, ball_loc_X, ball_loc_Y;

    ball_motion dut (
        .sys_clk    (clk),
        .sys_rst    (sys_rst),
        .vert_sync  (vert_sync),
        .accel_x    (accel_x),
        .accel_y    (accel_y),
        .accel_valid(accel_valid),
        .map_req    (map_req),
        .map_addr_x (map_addr_x),
        .map_addr_y (map_addr_y),
        .map_ack    (map_ack),
        .map_cell   (map_cell),
        .ball_loc_X (ball_loc_X),
        .ball_loc_Y (ball_loc_Y),
        .gameover   (gameover)
    );

    typedef struct {int x; int y; int go; int nreq;} exp_t;
    exp_t sb[$];

    int tests = 0, fails = 0;
    int wall_c = -1, wall_r = -1, goal_c = -1, goal_r = -1;
    bit ack_en = 1'b1;
    int req_total = 0, cur = 0, stab_err = 0;
    bit req_prev = 1'b0;
    int log_x [0:1023];
    int log_y [0:1023];
    int log_hi[0:1023];

    function automatic logic [1:0] cell_at(input logic [9:0] cx, input logic [9:0] cy);
        if (int'(cx) == wall_c && int'(cy) == wall_r) return 2'b01;
        if (int'(cx) == goal_c && int'(cy) == goal_r) return 2'b10;
        return 2'b00;
    endfunction

    // Map responder: acknowledges half a cycle after seeing a request, logs each probe.
    always @(negedge clk) begin
        if (map_req) begin
            if (!req_prev) begin
                cur = req_total % 1024;
                req_total++;
                log_x[cur]  = int'(map_addr_x);
                log_y[cur]  = int'(map_addr_y);
                log_hi[cur] = 0;
            end else if (int'(map_addr_x) != log_x[cur] || int'(map_addr_y) != log_y[cur]) begin
                stab_err++;
            end
            log_hi[cur]++;
            map_ack  = ack_en;
            map_cell = cell_at(map_addr_x, map_addr_y);
        end else begin
            map_ack = 1'b0;
        end
        req_prev = map_req;
    end

    task automatic chk(input string tag, input int obs, input int expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic do_reset();
        @(negedge clk) sys_rst = 1'b1;
        repeat (2) @(negedge clk);
        sys_rst = 1'b0;
    endtask

    task automatic strobe(input logic [7:0] ax, input logic [7:0] ay);
        @(negedge clk);
        accel_x = ax;
        accel_y = ay;
        accel_valid = 1'b1;
        @(negedge clk) accel_valid = 1'b0;
    endtask

    task automatic start_frame();
        @(negedge clk) vert_sync = 1'b0;
        @(negedge clk) vert_sync = 1'b1;
    endtask

    task automatic frame(input string tag, input int ex, input int ey, input int ego,
                         input int enreq, input int cyc);
        exp_t e;
        int base;
        sb.push_back('{ex, ey, ego, enreq});
        base = req_total;
        start_frame();
        repeat (cyc) @(negedge clk);
        e = sb.pop_front();
        chk({tag, ".x"}, int'(ball_loc_X), e.x);
        chk({tag, ".y"}, int'(ball_loc_Y), e.y);
        chk({tag, ".gameover"}, int'(gameover), e.go);
        if (e.nreq >= 0) chk({tag, ".nreq"}, req_total - base, e.nreq);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: bench did not reach its summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int b;
        sys_rst = 1'b1; vert_sync = 1'b1; accel_valid = 1'b0; accel_x = '0; accel_y = '0;
        do_reset();
        chk("rst.x", int'(ball_loc_X), 16);
        chk("rst.y", int'(ball_loc_Y), 16);
        chk("rst.gameover", int'(gameover), 0);
        chk("rst.req", int'(map_req), 0);
        chk("rst.addr_x", int'(map_addr_x), 0);
        chk("rst.addr_y", int'(map_addr_y), 0);
        frame("idle", 16, 16, 0, 0, 20);

        // Saturation: +127 tilt gives +7/frame at most.
        strobe(8'h7F, 8'h00);
        b = req_total;
        frame("sat1", 23, 16, 0, 2, 14);
        chk("sat1.probe_col", log_x[b], 38);
        chk("sat1.probe_row", log_y[b], 24);
        frame("sat2", 30, 16, 0, 2, 14);
        frame("sat3", 37, 16, 0, 2, 14);

        // Wall hit with vx=+4 from (16,16).
        do_reset();
        strobe(8'h40, 8'h00);
        wall_c = 35; wall_r = 24;
        b = req_total;
        frame("wall", 16, 16, 0, -1, 14);
        chk("wall.probe_col", log_x[b], 35);
        chk("wall.probe_row", log_y[b], 24);
        wall_c = -1; wall_r = -1;
        strobe(8'h00, 8'h00);
        frame("wall_next", 16, 16, 0, 0, 14);

        // Both axes moving, one-cycle acks: outputs change on the 9th edge after detection.
        do_reset();
        strobe(8'h70, 8'h20);
        b = req_total;
        start_frame();
        repeat (7) @(negedge clk);
        chk("lat.pre_commit_x", int'(ball_loc_X), 16);
        @(negedge clk);
        chk("lat.x", int'(ball_loc_X), 23);
        chk("lat.y", int'(ball_loc_Y), 18);
        repeat (4) @(negedge clk);
        chk("lat.nreq", req_total - b, 3);
        chk("lat.px_col", log_x[b], 38);
        chk("lat.px_row", log_y[b], 24);
        chk("lat.py_col", log_x[b+1], 31);
        chk("lat.py_row", log_y[b+1], 33);
        chk("lat.goal_col", log_x[b+2], 31);
        chk("lat.goal_row", log_y[b+2], 26);

        // Upward motion into the top edge.
        do_reset();
        strobe(8'h00, 8'hD0);
        b = req_total;
        frame("up1", 16, 13, 0, 2, 14);
        chk("up1.probe_col", log_x[b], 24);
        chk("up1.probe_row", log_y[b], 13);
        frame("up2", 16, 7, 0, 2, 14);
        frame("up3", 16, 0, 0, 2, 14);
        frame("up_clamp", 16, 0, 0, 0, 14);
        strobe(8'h00, 8'h10);
        frame("up_rebound", 16, 1, 0, 2, 14);

        // Right screen edge: ramp to 618, then 622, then clamp to 624.
        do_reset();
        strobe(8'h70, 8'h00);
        for (int k = 1; k <= 86; k++) frame($sformatf("ramp%0d", k), 16 + 7 * k, 16, 0, 2, 14);
        strobe(8'hD0, 8'h00);
        frame("edge622", 622, 16, 0, 2, 14);
        strobe(8'h10, 8'h00);
        b = req_total;
        frame("edge_clamp", 624, 16, 0, 2, 14);
        chk("edge_clamp.probe_col", log_x[b], 639);
        chk("edge_clamp.probe_row", log_y[b], 24);
        strobe(8'h00, 8'h00);
        frame("edge_after", 624, 16, 0, 0, 14);

        // Ack timeout with a second frame start arriving while busy.
        do_reset();
        strobe(8'h70, 8'h00);
        ack_en = 1'b0;
        b = req_total;
        start_frame();
        repeat (4) @(negedge clk);
        start_frame();
        for (int i = 0; i < 40 && map_req; i++) @(negedge clk);
        chk("tmo.req_dropped", int'(map_req), 0);
        ack_en = 1'b1;
        repeat (40) @(negedge clk);
        chk("tmo.x", int'(ball_loc_X), 16);
        chk("tmo.nreq", req_total - b, 1);
        chk("tmo.req_cycles", log_hi[b % 1024], 15);
        frame("tmo_next", 23, 16, 0, 2, 14);

        // Reset while a probe is outstanding.
        ack_en = 1'b0;
        start_frame();
        for (int i = 0; i < 20 && !map_req; i++) @(negedge clk);
        chk("rstmid.req_up", int'(map_req), 1);
        sys_rst = 1'b1;
        @(negedge clk);
        chk("rstmid.req", int'(map_req), 0);
        chk("rstmid.x", int'(ball_loc_X), 16);
        sys_rst = 1'b0;
        ack_en = 1'b1;
        frame("post_rst", 16, 16, 0, 0, 20);

        // Goal reached, then frozen until reset.
        strobe(8'h70, 8'h00);
        goal_c = 31; goal_r = 24;
        frame("goal", 23, 16, 1, 2, 14);
        frame("goal_frozen", 23, 16, 1, 0, 20);
        goal_c = -1; goal_r = -1;
        do_reset();
        chk("goal_rst.gameover", int'(gameover), 0);
        chk("goal_rst.x", int'(ball_loc_X), 16);

        chk("addr_stable", stab_err, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
